// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port data SRAM pair (two 256x8 macros forming one
//   DW-bit word) between the processor and the host loader port.
//   The processor normally wins. After STARVE_LIMIT consecutive cycles in
//   which a pending host request loses, the host is forced through and the
//   processor is stalled for that one cycle.
//
// Ports
//   clk, reset_n          clock (also clocks the SRAMs), async active-low reset
//   p_req/p_we/p_addr/p_wdata   processor access request
//   p_rdata               processor read data, valid the cycle after acceptance
//   p_stall               processor access not accepted this cycle
//   h_req/h_we/h_be/h_addr/h_wdata   host request, held until h_ack
//   h_ack, h_rdata        one-cycle host completion pulse and read data
//   mem_cen/mem_gwen/mem_wen/mem_addr/mem_d   SRAM drive (active-low controls)
//   mem_q                 SRAM read data, one cycle after address sampling
`timescale 1ns/1ps

module dmem_port_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            p_req,
  input  logic            p_we,
  input  logic [AW-1:0]   p_addr,
  input  logic [DW-1:0]   p_wdata,
  output logic [DW-1:0]   p_rdata,
  output logic            p_stall,
  input  logic            h_req,
  input  logic            h_we,
  input  logic [DW/8-1:0] h_be,
  input  logic [AW-1:0]   h_addr,
  input  logic [DW-1:0]   h_wdata,
  output logic            h_ack,
  output logic [DW-1:0]   h_rdata,
  output logic            mem_cen,
  output logic            mem_gwen,
  output logic [DW-1:0]   mem_wen,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_d,
  input  logic [DW-1:0]   mem_q
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = DW / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    H_ACK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          h_pending;
  logic          host_win;
  logic          p_access;
  logic          p_rd_q;
  logic [DW-1:0] p_hold;
  logic [DW-1:0] h_wen;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));

  // Arbitration is qualified by reset_n so the SRAM sees no access at all
  // while reset is asserted, even if requests are still held high.
  assign h_pending = reset_n && h_req && (state_q == IDLE);
  assign host_win  = h_pending && (!p_req || starved);
  assign p_access  = reset_n && p_req && !host_win;
  assign p_stall   = p_req && host_win;

  // Host byte enables expand to active-low per-bit write enables.
  always_comb begin
    h_wen = '1;
    for (int i = 0; i < BW; i++) begin
      h_wen[i*8 +: 8] = {8{~h_be[i]}};
    end
  end

  // SRAM drive: host grant, processor access, or idle.
  always_comb begin
    mem_cen  = 1'b1;
    mem_gwen = 1'b1;
    mem_wen  = '1;
    mem_addr = '0;
    mem_d    = '0;
    if (host_win) begin
      mem_cen  = 1'b0;
      mem_gwen = !h_we;
      mem_wen  = h_we ? h_wen : '1;
      mem_addr = h_addr;
      mem_d    = h_wdata;
    end else if (p_access) begin
      mem_cen  = 1'b0;
      mem_gwen = !p_we;
      mem_wen  = p_we ? '0 : '1;
      mem_addr = p_addr;
      mem_d    = p_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host_win) state_d = H_ACK;
      H_ACK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      starve_cnt <= '0;
      p_rd_q     <= 1'b0;
      p_hold     <= '0;
    end else begin
      state_q <= state_d;
      if (host_win || !h_req) begin
        starve_cnt <= '0;
      end else if (h_pending && p_req && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      p_rd_q <= p_access && !p_we;
      if (p_rd_q) begin
        p_hold <= mem_q;
      end
    end
  end

  // Read data comes straight from the macro on the return cycle and from
  // the hold register afterwards, so the processor sees a stable value.
  assign p_rdata = p_rd_q ? mem_q : p_hold;
  assign h_ack   = (state_q == H_ACK);
  assign h_rdata = h_ack ? mem_q : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps

module tb_dmem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int SL = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            p_req = 1'b0;
  logic            p_we = 1'b0;
  logic [AW-1:0]   p_addr = '0;
  logic [DW-1:0]   p_wdata = '0;
  logic [DW-1:0]   p_rdata;
  logic            p_stall;
  logic            h_req = 1'b0;
  logic            h_we = 1'b0;
  logic [DW/8-1:0] h_be = '0;
  logic [AW-1:0]   h_addr = '0;
  logic [DW-1:0]   h_wdata = '0;
  logic            h_ack;
  logic [DW-1:0]   h_rdata;
  logic            mem_cen;
  logic            mem_gwen;
  logic [DW-1:0]   mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_d;
  logic [DW-1:0]   mem_q = '0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_n(reset_n),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .h_req(h_req), .h_we(h_we), .h_be(h_be), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_ack(h_ack), .h_rdata(h_rdata),
    .mem_cen(mem_cen), .mem_gwen(mem_gwen), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
  );

  // Behavioural SRAM: bit-masked write, registered read data.
  logic [DW-1:0] sram [0:255];
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_gwen) sram[mem_addr] <= (sram[mem_addr] & mem_wen) | (mem_d & ~mem_wen);
      else           mem_q <= sram[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit            chk;
    logic [DW-1:0] d;
  } h_exp_t;

  h_exp_t        h_q[$];
  logic [DW-1:0] p_q[$];
  bit            p_pend = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: host results pop on h_ack, processor read data pops the
  // cycle after an accepted read.
  always @(negedge clk) begin
    h_exp_t e;
    if (h_ack) begin
      if (h_q.size() == 0) chk_eq("h_ack_unexpected", 32'(h_ack), 32'h0);
      else begin
        e = h_q.pop_front();
        if (e.chk) chk_eq("h_rdata", 32'(h_rdata), 32'(e.d));
      end
    end
    if (p_pend) begin
      if (p_q.size() == 0) chk_eq("p_rdata_unexpected", 32'(p_pend), 32'h0);
      else chk_eq("p_rdata", 32'(p_rdata), 32'(p_q.pop_front()));
    end
    p_pend = reset_n && p_req && !p_we && !p_stall;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step();
    p_req = 1'b0; p_we = 1'b0;
    h_req = 1'b0; h_we = 1'b0;
  endtask

  task automatic p_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step();
    p_req = 1'b1; p_we = 1'b1; p_addr = a; p_wdata = d;
  endtask

  task automatic p_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    step();
    p_req = 1'b1; p_we = 1'b0; p_addr = a;
    p_q.push_back(exp);
  endtask

  // Issues one host access; returns cycles from request to h_ack and the
  // mem_wen seen on the cycle before h_ack (the grant cycle).
  task automatic host_op(input logic we, input logic [1:0] be, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                         output int lat, output logic [DW-1:0] wen_g);
    h_exp_t e;
    bit got;
    step();
    h_req = 1'b1; h_we = we; h_be = be; h_addr = a; h_wdata = wd;
    e.chk = !we; e.d = exp_rd;
    h_q.push_back(e);
    got = 1'b0; lat = 0; wen_g = '1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (h_ack) got = 1'b1;
      else begin
        wen_g = mem_wen;
        lat++;
      end
    end
    if (!got) chk_eq("h_ack_timeout", 32'h0, 32'h1);
    step();
    h_req = 1'b0; h_we = 1'b0;
  endtask

  // Processor requests every cycle while the host waits from cycle 0.
  // The host must be forced through at cycle SL and acknowledged at SL+1.
  task automatic starve_run(input bit rd_at_force, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    h_exp_t e;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 0) begin
        h_req = 1'b1; h_we = 1'b1; h_be = 2'b11; h_addr = ha; h_wdata = hd;
        e.chk = 1'b0; e.d = '0;
        h_q.push_back(e);
      end
      if (c == SL + 2) begin
        h_req = 1'b0; h_we = 1'b0;
      end
      if (c < SL) begin
        p_req = 1'b1; p_we = 1'b1; p_addr = 8'h80; p_wdata = 16'h1000 + 16'(c);
      end else if (c == SL) begin
        p_req = 1'b1;
        if (rd_at_force) begin
          p_we = 1'b0; p_addr = ha;
          p_q.push_back(hd);
        end else begin
          p_we = 1'b1; p_addr = 8'h80; p_wdata = 16'h1008;
        end
      end else if (c >= SL + 2) begin
        p_req = 1'b0; p_we = 1'b0;
      end
      @(negedge clk);
      chk_eq($sformatf("p_stall_c%0d", c), 32'(p_stall), 32'(c == SL));
      chk_eq($sformatf("h_ack_c%0d", c), 32'(h_ack), 32'(c == SL + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [DW-1:0] wen_g;
    logic [DW-1:0] seq_d [3];
    seq_d[0] = 16'h1111; seq_d[1] = 16'h2222; seq_d[2] = 16'h3333;

    // Reset state, with a host request held during reset.
    h_req = 1'b1; h_we = 1'b1; h_be = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_h_ack", 32'(h_ack), 'h0);
    chk_eq("rst_h_rdata", 32'(h_rdata), 'h0);
    chk_eq("rst_p_rdata", 32'(p_rdata), 'h0);
    chk_eq("rst_p_stall", 32'(p_stall), 'h0);
    chk_eq("rst_mem_cen", 32'(mem_cen), 'h1);
    chk_eq("rst_mem_gwen", 32'(mem_gwen), 'h1);
    chk_eq("rst_mem_wen", 32'(mem_wen), 'hFFFF);
    step();
    reset_n = 1'b1; h_req = 1'b0; h_we = 1'b0;

    // Host full-word write then read.
    host_op(1'b1, 2'b11, 8'h12, 16'hBEEF, 16'h0, lat, wen_g);
    chk_eq("hw_latency", 32'(lat), 'h1);
    chk_eq("hw_wen_full", 32'(wen_g), 'h0000);
    host_op(1'b0, 2'b11, 8'h12, 16'h0, 16'hBEEF, lat, wen_g);
    chk_eq("hr_latency", 32'(lat), 'h1);

    // Byte enables, including an all-zero enable write.
    host_op(1'b1, 2'b01, 8'h12, 16'h1234, 16'h0, lat, wen_g);
    chk_eq("hw_wen_lo", 32'(wen_g), 'hFF00);
    host_op(1'b1, 2'b00, 8'h12, 16'h0000, 16'h0, lat, wen_g);
    chk_eq("hw_wen_none", 32'(wen_g), 'hFFFF);
    chk_eq("hw_be0_latency", 32'(lat), 'h1);
    host_op(1'b0, 2'b11, 8'h12, 16'h0, 16'hBE34, lat, wen_g);

    // Processor preload, then back-to-back reads.
    p_write(8'h00, 16'h1111);
    p_write(8'h01, 16'h2222);
    p_write(8'h02, 16'h3333);
    p_write(8'h40, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      p_read(8'(i), seq_d[i]);
      @(negedge clk);
      chk_eq($sformatf("p_seq_stall%0d", i), 32'(p_stall), 'h0);
    end
    idle();
    step();
    @(negedge clk);
    chk_eq("p_rdata_hold", 32'(p_rdata), 'h3333);

    // Starvation with continuous processor writes.
    starve_run(1'b0, 8'h90, 16'h5A5A);
    p_read(8'h80, 16'h1008);
    idle();
    host_op(1'b0, 2'b11, 8'h90, 16'h0, 16'h5A5A, lat, wen_g);

    // Collision: forced host write and stalled processor read of 0x40.
    starve_run(1'b1, 8'h40, 16'hA5A5);
    idle();

    // Reset asserted during the host grant cycle.
    step();
    h_req = 1'b1; h_we = 1'b1; h_be = 2'b11; h_addr = 8'h33; h_wdata = 16'h7777;
    @(negedge clk);
    chk_eq("rg_mem_cen", 32'(mem_cen), 'h0);
    reset_n = 1'b0;
    #1;
    chk_eq("rg_cen_in_reset", 32'(mem_cen), 'h1);
    chk_eq("rg_wen_in_reset", 32'(mem_wen), 'hFFFF);
    @(posedge clk);
    @(negedge clk);
    chk_eq("rg_no_ack", 32'(h_ack), 'h0);
    step();
    reset_n = 1'b1; h_req = 1'b0; h_we = 1'b0;
    host_op(1'b1, 2'b11, 8'h33, 16'h7777, 16'h0, lat, wen_g);
    chk_eq("rg_reissue_latency", 32'(lat), 'h1);
    host_op(1'b0, 2'b11, 8'h33, 16'h0, 16'h7777, lat, wen_g);

    idle();
    repeat (2) step();
    chk_eq("h_queue_drained", 32'(h_q.size()), 'h0);
    chk_eq("p_queue_drained", 32'(p_q.size()), 'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Arbitrates the single-port data SRAM pair (two 256x8 GF180 macros forming one 16-bit word) between the pipelined processor and a host loader port driven from the IO/LA interface. The processor has priority. A starvation counter guarantees the host a slot by stalling the processor for one cycle. The block sits between the processor, the IO interface and the SRAM macros, and drives their active-low control pins directly.

Parameters:
AW, 8, SRAM word address width
DW, 16, data width (two 8-bit macros)
STARVE_LIMIT, 8, consecutive host-losing cycles before the host is forced through (must be >=1)

Ports:
clk  in  1  system clock, also clocks the SRAMs
reset_n  in  1  asynchronous active-low reset
p_req  in  1  processor access valid this cycle
p_we  in  1  processor write (1) / read (0)
p_addr  in  AW  processor word address
p_wdata  in  DW  processor write data
p_rdata  out  DW  processor read data, valid the cycle after the accepted read
p_stall  out  1  processor access not accepted; processor must hold request
h_req  in  1  host request; held high until h_ack
h_we  in  1  host write (1) / read (0)
h_be  in  DW/8  host byte enables for writes
h_addr  in  AW  host word address
h_wdata  in  DW  host write data
h_ack  out  1  one-cycle completion pulse
h_rdata  out  DW  host read data, valid while h_ack=1
mem_cen  out  1  SRAM chip enable, active low
mem_gwen  out  1  SRAM global write enable, active low
mem_wen  out  DW  SRAM per-bit write enable, active low
mem_addr  out  AW  SRAM address
mem_d  out  DW  SRAM write data
mem_q  in  DW  SRAM read data (valid the cycle after the address is sampled)

Behaviour:
- FSM with two states. IDLE: host may be granted. H_ACK: the cycle after a host grant.
  - IDLE -> H_ACK on host grant.
  - H_ACK -> IDLE unconditionally.
- h_pending = h_req && state==IDLE.
- host_win = h_pending && (!p_req || starve_cnt == STARVE_LIMIT). Combinational.
- p_stall = p_req && host_win. Combinational. The processor is stalled for at most 1 cycle per STARVE_LIMIT+1 cycles.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when h_pending && p_req && !host_win.
  - Clears on a host grant or when h_req=0.
- SRAM drive, by case:
  - Host grant: cen=0; gwen=!h_we; wen = h_we ? ~(each h_be bit replicated x8) : all 1; addr=h_addr; d=h_wdata.
  - Processor access (p_req && !host_win): cen=0; gwen=!p_we; wen = p_we ? all 0 : all 1; addr=p_addr; d=p_wdata.
  - No access: cen=1, gwen=1, wen all 1, addr=0, d=0.
- Host completion:
  - h_ack=1 exactly in state H_ACK, for writes and reads alike.
  - h_rdata = mem_q in that cycle. h_rdata=0 otherwise.
  - Peak host throughput is one access per 2 cycles.
  - The processor may use the port during H_ACK.
- Processor read data:
  - A register p_rd_q is set when a processor read is accepted.
  - When p_rd_q=1, p_rdata = mem_q and mem_q is captured into a hold register.
  - When p_rd_q=0, p_rdata = the hold register value.
- Write/read collision on the same address: the grant order decides. A host write that stalls a processor read makes the read return the new data one cycle later.
- Host write with h_be=0: the cycle is consumed with wen all 1, no cells are modified, and h_ack is still pulsed.
- Reset (asynchronous, any time):
  - State returns to IDLE; starve_cnt=0; p_rd_q=0; hold register=0.
  - h_ack=0, h_rdata=0, p_rdata=0, p_stall=0 when p_req=0.
  - mem_cen=1, mem_gwen=1, mem_wen all 1.
  - An in-flight host transaction is dropped with no h_ack. The host must re-request.
- No combinational path from mem_q to any SRAM control output.

Test Plan:
- Host write then read with p_req=0: write addr 0x12 data 0xBEEF, be=2'b11 -> h_ack 1 cycle after request, mem_wen=16'h0000 during the grant cycle. Read 0x12 -> h_rdata=0xBEEF with h_ack.
- Byte enables: preload 0x12=0xBEEF, host write 0x1234 with be=2'b01 -> mem_wen=16'hFF00 during the grant cycle. Read back -> 0xBE34.
- Processor back-to-back reads with p_req=1 every cycle and no host traffic: addresses 0x00,0x01,0x02 preloaded 0x1111,0x2222,0x3333 -> p_rdata sequence 0x1111,0x2222,0x3333, one cycle after each address, p_stall never 1.
- Starvation, STARVE_LIMIT=8: p_req held 1 continuously, h_req asserted at cycle 0 -> p_stall=1 at cycle 8 only, h_ack at cycle 9, starve_cnt=0 afterwards.
- Collision: processor reads 0x40 (old value 0x0000) in the same cycle the host is forced through writing 0x40=0xA5A5 -> p_stall in that cycle, processor read accepted next cycle, p_rdata=0xA5A5.
- Reset mid-transaction: reset_n pulled low in the host grant cycle -> no h_ack, mem_cen=1 immediately. After release, a re-issued h_req completes normally.
